hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Single clock domain; reset synchronous, active-low.
REQ-002 i_clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  synchronous reset, active-low.
REQ-004 i_id_rs1, i_id_rs2  in  5 each  source register indices of instruction in ID.
REQ-005 i_id_use_rs1, i_id_use_rs2  in  1 each  ID instruction reads that source.
REQ-006 i_ex_rd, i_mem_rd  in  5 each  destination indices in EX and MEM.
REQ-007 i_ex_rd_wen, i_mem_rd_wen  in  1 each  EX/MEM instruction writes rd.
REQ-008 i_ex_dmem_ren  in  1  EX instruction is a load.
REQ-009 i_ex_redirect  in  1  taken branch, JAL or JALR resolved in EX this cycle.
REQ-010 i_dmem_busy  in  1  data memory has not completed the current access.
REQ-011 i_wb_halt  in  1  halting instruction retiring in WB.
REQ-012 o_pc_stall, o_ifid_stall  out  1 each  hold PC / IF-ID register.
REQ-013 o_ifid_flush, o_idex_bubble  out  1 each  zero IF-ID / insert NOP into ID-EX.
REQ-014 o_pipe_freeze  out  1  hold EX-MEM and MEM-WB registers.
REQ-015 o_halted  out  1  core halted.
REQ-016 o_state  out  2  FSM state: 00 RUN, 01 STALL, 10 WAIT, 11 HALT.
REQ-017 o_stall_cnt, o_flush_cnt  out  16 each  saturating event counters.

Function
REQ-018 Hazard match on x0 never counts: rd == 0 never causes a data hazard.
REQ-019 Load-use hazard: i_ex_dmem_ren & i_ex_rd_wen & rd matches a used ID source.
REQ-020 Data hazard = load-use hazard, plus REQ-041 terms when FORWARDING_EN is absent.
REQ-021 Priority, highest first: HALT, dmem busy, redirect, data hazard.
REQ-022 HALT: pc/ifid stall, freeze, and bubble all 1; flush 0.
REQ-023 dmem busy (not HALT): pc/ifid stall, freeze, and bubble all 1; flush 0; redirect and hazards ignored that cycle.
REQ-024 Redirect (no busy): flush=1, bubble=1, stalls=0, freeze=0; any data hazard is discarded that cycle.
REQ-025 Data hazard alone: pc/ifid stall=1, bubble=1, flush=0, freeze=0.
REQ-026 No event: all control outputs 0.
REQ-027 Control outputs are combinational from the registered state and the current inputs.
REQ-028 Zero-latency response: a hazard present in a cycle stalls in that same cycle.
REQ-029 Next state: HALT is sticky; else i_wb_halt -> HALT; else busy -> WAIT; else data hazard without redirect -> STALL; else RUN.
REQ-030 o_state reflects the registered state, i.e. the event of the previous cycle.
REQ-031 i_wb_halt together with busy or redirect: HALT wins; the current cycle still uses the REQ-023/024 outputs.
REQ-032 o_halted = (state == HALT).
REQ-033 o_stall_cnt increments on each edge where o_pc_stall=1 and state != HALT; it saturates at 0xFFFF.
REQ-034 o_flush_cnt increments on each edge where o_ifid_flush=1; it saturates at 0xFFFF.
REQ-035 A load-use stall lasts exactly 1 cycle with forwarding: the bubble moves the load to MEM.

Reset
REQ-036 When i_rst_n=0 at an edge: state <= RUN, and both counters <= 0.
REQ-037 While i_rst_n=0, outputs are: flush=1, bubble=1, stalls=0, freeze=0, halted=0.
REQ-038 Reset asserted mid-stall, mid-wait or in HALT aborts the operation; RUN follows on the first edge after release.

Configuration
REQ-039 Macro HAZARD_CTRL_FORWARDING_EN selects the hazard set.
REQ-040 Defined: only load-use is a data hazard, because a full EX/MEM forwarding network exists.
REQ-041 Undefined: also hazard on any used source matching i_ex_rd (i_ex_rd_wen) or i_mem_rd (i_mem_rd_wen). WB writes are visible via regfile write-through, so WB is never a hazard.

Verification
REQ-042 lw x5 in EX, ID add x6,x5,x1 -> 1 cycle stall+bubble, state STALL next cycle, stall_cnt=1; no second stall (forwarding on).
REQ-043 Same stream, macro undefined, add x6,x5,x1 follows addi x5 -> stall 2 cycles (EX match, then MEM match), stall_cnt=2.
REQ-044 i_ex_redirect=1 together with a load-use match in the MEM-term build -> flush=1, bubble=1, no stall, flush_cnt=1, state RUN.
REQ-045 i_dmem_busy high 3 cycles during redirect -> freeze 3 cycles with no flush, then flush on cycle 4; state WAIT x3 then RUN.
REQ-046 i_wb_halt=1 -> next cycle HALT, o_halted=1, all stalls held; drop i_rst_n 1 cycle -> RUN with counters 0.
REQ-047 Force 70000 stall cycles -> o_stall_cnt holds at 0xFFFF; ID source x0 vs EX rd x0 load -> no stall.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline (master) and hazard_ctrl (slave).
// Carries ID/EX/MEM operand info and the stall/flush/freeze controls back.
interface hazard_ctrl_if;
  logic [4:0]  i_id_rs1;
  logic [4:0]  i_id_rs2;
  logic        i_id_use_rs1;
  logic        i_id_use_rs2;
  logic [4:0]  i_ex_rd;
  logic [4:0]  i_mem_rd;
  logic        i_ex_rd_wen;
  logic        i_mem_rd_wen;
  logic        i_ex_dmem_ren;
  logic        i_ex_redirect;
  logic        i_dmem_busy;
  logic        i_wb_halt;
  logic        o_pc_stall;
  logic        o_ifid_stall;
  logic        o_ifid_flush;
  logic        o_idex_bubble;
  logic        o_pipe_freeze;
  logic        o_halted;
  logic [1:0]  o_state;
  logic [15:0] o_stall_cnt;
  logic [15:0] o_flush_cnt;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_ex_rd, i_mem_rd, i_ex_rd_wen, i_mem_rd_wen,
           i_ex_dmem_ren, i_ex_redirect, i_dmem_busy, i_wb_halt,
    input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_bubble,
           o_pipe_freeze, o_halted, o_state, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
           i_ex_rd, i_mem_rd, i_ex_rd_wen, i_mem_rd_wen,
           i_ex_dmem_ren, i_ex_redirect, i_dmem_busy, i_wb_halt,
    output o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_bubble,
           o_pipe_freeze, o_halted, o_state, o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: zero-latency stall/flush/freeze from registered state + inputs.
// HAZARD_CTRL_FORWARDING_EN defined: only load-use stalls; undefined: EX/MEM rd matches stall too.
module hazard_ctrl (
  input logic          i_clk,
  input logic          i_rst_n,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;
  logic ex_hit, mem_hit, load_use, data_haz;
  logic pc_stall, ifid_stall, ifid_flush, idex_bubble, pipe_freeze;

  // x0 is hard-wired zero, so a write to it can never create a dependency
  assign rs1_ex_hit  = hz.i_id_use_rs1 && (hz.i_id_rs1 != 5'd0) && (hz.i_id_rs1 == hz.i_ex_rd);
  assign rs2_ex_hit  = hz.i_id_use_rs2 && (hz.i_id_rs2 != 5'd0) && (hz.i_id_rs2 == hz.i_ex_rd);
  assign rs1_mem_hit = hz.i_id_use_rs1 && (hz.i_id_rs1 != 5'd0) && (hz.i_id_rs1 == hz.i_mem_rd);
  assign rs2_mem_hit = hz.i_id_use_rs2 && (hz.i_id_rs2 != 5'd0) && (hz.i_id_rs2 == hz.i_mem_rd);
  assign ex_hit      = rs1_ex_hit | rs2_ex_hit;
  assign mem_hit     = rs1_mem_hit | rs2_mem_hit;
  assign load_use    = hz.i_ex_dmem_ren & hz.i_ex_rd_wen & ex_hit;

`ifdef HAZARD_CTRL_FORWARDING_EN
  assign data_haz = load_use;
`else
  assign data_haz = load_use | (hz.i_ex_rd_wen & ex_hit) | (hz.i_mem_rd_wen & mem_hit);
`endif

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (!i_rst_n) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state == ST_HALT || hz.i_dmem_busy) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
      pipe_freeze = 1'b1;
    end else if (hz.i_ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (data_haz) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  // A halting instruction retiring outranks a busy memory or a redirect
  always_comb begin
    state_nxt = ST_RUN;
    if (state == ST_HALT || hz.i_wb_halt)
      state_nxt = ST_HALT;
    else if (hz.i_dmem_busy)
      state_nxt = ST_WAIT;
    else if (data_haz && !hz.i_ex_redirect)
      state_nxt = ST_STALL;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_RUN;
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (pc_stall && state != ST_HALT && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (ifid_flush && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign hz.o_pc_stall    = pc_stall;
  assign hz.o_ifid_stall  = ifid_stall;
  assign hz.o_ifid_flush  = ifid_flush;
  assign hz.o_idex_bubble = idex_bubble;
  assign hz.o_pipe_freeze = pipe_freeze;
  assign hz.o_halted      = i_rst_n && (state == ST_HALT);
  assign hz.o_state       = state;
  assign hz.o_stall_cnt   = stall_cnt;
  assign hz.o_flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; ctl vector is {pc_stall, ifid_stall, flush, bubble, freeze, halted}.
module tb_hazard_ctrl;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  logic [5:0] ctl;

  hazard_ctrl_if hz_if ();

  hazard_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hz      (hz_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ctl = {hz_if.o_pc_stall, hz_if.o_ifid_stall, hz_if.o_ifid_flush,
                hz_if.o_idex_bubble, hz_if.o_pipe_freeze, hz_if.o_halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    hz_if.i_id_rs1      = 5'd0;
    hz_if.i_id_rs2      = 5'd0;
    hz_if.i_id_use_rs1  = 1'b0;
    hz_if.i_id_use_rs2  = 1'b0;
    hz_if.i_ex_rd       = 5'd0;
    hz_if.i_mem_rd      = 5'd0;
    hz_if.i_ex_rd_wen   = 1'b0;
    hz_if.i_mem_rd_wen  = 1'b0;
    hz_if.i_ex_dmem_ren = 1'b0;
    hz_if.i_ex_redirect = 1'b0;
    hz_if.i_dmem_busy   = 1'b0;
    hz_if.i_wb_halt     = 1'b0;
  endtask

  // lw x5 in EX, add x6,x5,x1 in ID
  task automatic set_ld_use();
    hz_if.i_ex_dmem_ren = 1'b1;
    hz_if.i_ex_rd       = 5'd5;
    hz_if.i_ex_rd_wen   = 1'b1;
    hz_if.i_id_rs1      = 5'd5;
    hz_if.i_id_rs2      = 5'd1;
    hz_if.i_id_use_rs1  = 1'b1;
    hz_if.i_id_use_rs2  = 1'b1;
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    clr_in();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ctl", ctl, 6'b001100);
    chk("rst_state", hz_if.o_state, 2'b00);
    chk("rst_scnt", hz_if.o_stall_cnt, 16'd0);
    chk("rst_fcnt", hz_if.o_flush_cnt, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_ctl", ctl, 6'b000000);
    tick();
    chk("idle_state", hz_if.o_state, 2'b00);

    // load-use stream
    set_ld_use();
    #1;
    chk("lu_ctl", ctl, 6'b110100);
    chk("lu_state_pre", hz_if.o_state, 2'b00);
    tick();
    chk("lu_state", hz_if.o_state, 2'b01);
    chk("lu_scnt", hz_if.o_stall_cnt, 16'd1);
    hz_if.i_ex_dmem_ren = 1'b0;
    hz_if.i_ex_rd_wen   = 1'b0;
    hz_if.i_ex_rd       = 5'd0;
    hz_if.i_mem_rd      = 5'd5;
    hz_if.i_mem_rd_wen  = 1'b1;
    #1;
`ifdef HAZARD_CTRL_FORWARDING_EN
    chk("lu_mem_ctl", ctl, 6'b000000);
    tick();
    chk("lu_mem_state", hz_if.o_state, 2'b00);
    chk("lu_mem_scnt", hz_if.o_stall_cnt, 16'd1);
`else
    chk("lu_mem_ctl", ctl, 6'b110100);
    tick();
    chk("lu_mem_state", hz_if.o_state, 2'b01);
    chk("lu_mem_scnt", hz_if.o_stall_cnt, 16'd2);
`endif
    clr_in();
    #1;
    chk("lu_done_ctl", ctl, 6'b000000);
    tick();
    chk("lu_done_state", hz_if.o_state, 2'b00);

    set_ld_use();
    hz_if.i_id_use_rs1 = 1'b0;
    #1;
    chk("unused_src_ctl", ctl, 6'b000000);

    // addi x5 then add x6,x5,x1
    do_reset();
    hz_if.i_ex_rd      = 5'd5;
    hz_if.i_ex_rd_wen  = 1'b1;
    hz_if.i_id_rs1     = 5'd5;
    hz_if.i_id_use_rs1 = 1'b1;
    #1;
`ifdef HAZARD_CTRL_FORWARDING_EN
    chk("alu_ex_ctl", ctl, 6'b000000);
`else
    chk("alu_ex_ctl", ctl, 6'b110100);
`endif
    tick();
    hz_if.i_ex_rd      = 5'd0;
    hz_if.i_ex_rd_wen  = 1'b0;
    hz_if.i_mem_rd     = 5'd5;
    hz_if.i_mem_rd_wen = 1'b1;
    #1;
`ifdef HAZARD_CTRL_FORWARDING_EN
    chk("alu_mem_ctl", ctl, 6'b000000);
    tick();
    chk("alu_scnt", hz_if.o_stall_cnt, 16'd0);
`else
    chk("alu_mem_ctl", ctl, 6'b110100);
    tick();
    chk("alu_scnt", hz_if.o_stall_cnt, 16'd2);
`endif

    // redirect discards a coincident load-use hazard
    do_reset();
    set_ld_use();
    hz_if.i_ex_redirect = 1'b1;
    #1;
    chk("redir_ctl", ctl, 6'b001100);
    tick();
    chk("redir_fcnt", hz_if.o_flush_cnt, 16'd1);
    chk("redir_scnt", hz_if.o_stall_cnt, 16'd0);
    chk("redir_state", hz_if.o_state, 2'b00);

    // busy memory holds off a pending redirect
    do_reset();
    hz_if.i_ex_redirect = 1'b1;
    hz_if.i_dmem_busy   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_ctl", ctl, 6'b110110);
      tick();
      chk("busy_state", hz_if.o_state, 2'b10);
    end
    hz_if.i_dmem_busy = 1'b0;
    #1;
    chk("busy_end_ctl", ctl, 6'b001100);
    tick();
    chk("busy_end_state", hz_if.o_state, 2'b00);
    chk("busy_end_fcnt", hz_if.o_flush_cnt, 16'd1);
    chk("busy_end_scnt", hz_if.o_stall_cnt, 16'd3);

    // halt with busy: busy outputs now, HALT next
    do_reset();
    hz_if.i_wb_halt   = 1'b1;
    hz_if.i_dmem_busy = 1'b1;
    #1;
    chk("halt_req_ctl", ctl, 6'b110110);
    tick();
    chk("halt_state", hz_if.o_state, 2'b11);
    clr_in();
    hz_if.i_ex_redirect = 1'b1;
    #1;
    chk("halt_ctl", ctl, 6'b110111);
    tick();
    chk("halt_sticky", hz_if.o_state, 2'b11);
    chk("halt_scnt", hz_if.o_stall_cnt, 16'd1);
    chk("halt_fcnt", hz_if.o_flush_cnt, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("halt_rst_ctl", ctl, 6'b001100);
    tick();
    rst_n = 1'b1;
    clr_in();
    #1;
    chk("halt_rst_state", hz_if.o_state, 2'b00);
    chk("halt_rst_scnt", hz_if.o_stall_cnt, 16'd0);
    chk("halt_rst_fcnt", hz_if.o_flush_cnt, 16'd0);
    chk("halt_rst_ctl2", ctl, 6'b000000);

    // stall counter saturation
    do_reset();
    set_ld_use();
    repeat (65534) tick();
    chk("sat_fffe", hz_if.o_stall_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", hz_if.o_stall_cnt, 16'hFFFF);
    repeat (4465) tick();
    chk("sat_hold", hz_if.o_stall_cnt, 16'hFFFF);
    chk("sat_state", hz_if.o_state, 2'b01);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midstall_rst_state", hz_if.o_state, 2'b00);
    chk("midstall_rst_scnt", hz_if.o_stall_cnt, 16'd0);

    // x0 never creates a hazard
    clr_in();
    hz_if.i_ex_dmem_ren = 1'b1;
    hz_if.i_ex_rd_wen   = 1'b1;
    hz_if.i_mem_rd_wen  = 1'b1;
    hz_if.i_id_use_rs1  = 1'b1;
    hz_if.i_id_use_rs2  = 1'b1;
    #1;
    chk("x0_ctl", ctl, 6'b000000);
    tick();
    chk("x0_state", hz_if.o_state, 2'b00);
    chk("x0_scnt", hz_if.o_stall_cnt, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
